// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes, responder FSM states and lane-mask helper
// for the RAM-backed slave.
package tl_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte lanes a PutFullData of 2^size bytes at this word offset must enable.
    function automatic logic [7:0] size_mask(input logic [1:0] size, input logic [2:0] addr);
        logic [7:0] lanes;
        case (size)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << addr;
    endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL A/D channel bundle shared by the cpu masters and memory slaves.
interface tilelink;

    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic [63:0] d_data;
    logic        d_denied;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_denied
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_denied
    );

endinterface

// File: rtl/sram_1rw.sv
// Single-port DEPTHx64 RAM with per-byte write enables and a registered read.
module sram_1rw #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               be,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];

    // rdata only changes on a read, so it holds the last word fetched.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL responder in front of sram_1rw: one transaction in flight,
// optional wait states, and access checks on every request.
module tl_ram_slave
    import tl_pkg::*;
#(
    parameter logic [63:0] BASE        = 64'h8000_0000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0
) (
    input logic    clk,
    input logic    rst,
    tilelink.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t state, state_next;
    logic   accept, commit;

    logic [2:0]  req_opcode;
    logic [1:0]  req_size;
    logic [3:0]  req_source;
    logic [63:0] req_address;
    logic [7:0]  req_mask;
    logic [63:0] req_data;
    logic [3:0]  wait_cnt;

    logic [2:0]  cur_opcode;
    logic [1:0]  cur_size;
    logic [3:0]  cur_source;
    logic [63:0] cur_address;
    logic [7:0]  cur_mask;
    logic [63:0] cur_data;

    logic          in_range, aligned, known_op, bad_mask, denied, is_get;
    logic          ram_en;
    logic [AW-1:0] ram_index;
    logic [63:0]   ram_rdata;

    logic [2:0] resp_opcode;
    logic [1:0] resp_size;
    logic [3:0] resp_source;
    logic       resp_denied;
    logic       resp_has_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With no wait states the commit edge is the accept edge itself.
    always_comb begin
        state_next  = state;
        bus.a_ready = 1'b0;
        bus.d_valid = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                bus.a_ready = !rst;
                if (bus.a_valid && !rst) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                    end else begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.d_valid = 1'b1;
                if (bus.d_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_opcode  <= bus.a_opcode;
            req_size    <= bus.a_size;
            req_source  <= bus.a_source;
            req_address <= bus.a_address;
            req_mask    <= bus.a_mask;
            req_data    <= bus.a_data;
        end
    end

    // The request being committed comes straight off the bus in IDLE, else from the latch.
    always_comb begin
        if (state == IDLE) begin
            cur_opcode  = bus.a_opcode;
            cur_size    = bus.a_size;
            cur_source  = bus.a_source;
            cur_address = bus.a_address;
            cur_mask    = bus.a_mask;
            cur_data    = bus.a_data;
        end else begin
            cur_opcode  = req_opcode;
            cur_size    = req_size;
            cur_source  = req_source;
            cur_address = req_address;
            cur_mask    = req_mask;
            cur_data    = req_data;
        end
    end

    always_comb begin
        in_range = (cur_address >= BASE) && ((cur_address - BASE) < 64'(8 * DEPTH));
        case (cur_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !cur_address[0];
            2'd2:    aligned = ~|cur_address[1:0];
            default: aligned = ~|cur_address[2:0];
        endcase
        is_get    = (cur_opcode == A_GET);
        known_op  = is_get || (cur_opcode == A_PUT_FULL) || (cur_opcode == A_PUT_PARTIAL);
        bad_mask  = (cur_opcode == A_PUT_FULL) && (cur_mask != size_mask(cur_size, cur_address[2:0]));
        denied    = !in_range || !aligned || !known_op || bad_mask;
        ram_index = AW'((cur_address - BASE) >> 3);
        ram_en    = commit && !denied && !rst;
    end

    sram_1rw #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (!is_get),
        .addr  (ram_index),
        .be    (cur_mask),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_opcode   <= D_ACCESS_ACK;
            resp_size     <= 2'd0;
            resp_source   <= 4'd0;
            resp_denied   <= 1'b0;
            resp_has_data <= 1'b0;
        end else if (commit) begin
            resp_opcode   <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
            resp_size     <= cur_size;
            resp_source   <= cur_source;
            resp_denied   <= denied;
            resp_has_data <= is_get && !denied;
        end
    end

    assign bus.d_opcode = resp_opcode;
    assign bus.d_size   = resp_size;
    assign bus.d_source = resp_source;
    assign bus.d_denied = resp_denied;
    assign bus.d_data   = resp_has_data ? ram_rdata : 64'd0;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave: a zero-wait instance for the vector table
// and a three-wait instance for backpressure and mid-transaction reset.
module tb_tl_ram_slave;
    import tl_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_ready;

    int checks = 0;
    int errors = 0;

    tilelink bus0();
    tilelink bus3();

    assign bus0.a_valid   = a_valid && !sel;
    assign bus3.a_valid   = a_valid && sel;
    assign bus0.a_opcode  = a_opcode;
    assign bus3.a_opcode  = a_opcode;
    assign bus0.a_size    = a_size;
    assign bus3.a_size    = a_size;
    assign bus0.a_source  = a_source;
    assign bus3.a_source  = a_source;
    assign bus0.a_address = a_address;
    assign bus3.a_address = a_address;
    assign bus0.a_mask    = a_mask;
    assign bus3.a_mask    = a_mask;
    assign bus0.a_data    = a_data;
    assign bus3.a_data    = a_data;
    assign bus0.d_ready   = d_ready;
    assign bus3.d_ready   = d_ready;

    logic        o_a_ready, o_d_valid, o_d_denied;
    logic [2:0]  o_d_opcode;
    logic [1:0]  o_d_size;
    logic [3:0]  o_d_source;
    logic [63:0] o_d_data;

    assign o_a_ready  = sel ? bus3.a_ready  : bus0.a_ready;
    assign o_d_valid  = sel ? bus3.d_valid  : bus0.d_valid;
    assign o_d_denied = sel ? bus3.d_denied : bus0.d_denied;
    assign o_d_opcode = sel ? bus3.d_opcode : bus0.d_opcode;
    assign o_d_size   = sel ? bus3.d_size   : bus0.d_size;
    assign o_d_source = sel ? bus3.d_source : bus0.d_source;
    assign o_d_data   = sel ? bus3.d_data   : bus0.d_data;

    tl_ram_slave #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    tl_ram_slave #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [1:0]  size;
        logic [3:0]  src;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [2:0]  exp_op;
        logic        exp_denied;
        logic [63:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    logic [2:0]  r_op;
    logic        r_den;
    logic [63:0] r_data;
    logic [3:0]  r_src;
    logic [1:0]  r_size;
    int          r_lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic s, input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                          input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                          input logic [2:0] eop, input logic eden, input logic [63:0] edata, input int elat);
        vec_t v;
        v.sel = s; v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
        v.exp_op = eop; v.exp_denied = eden; v.exp_data = edata; v.exp_lat = elat;
        vecs.push_back(v);
    endtask

    // One full A/D transaction with d_ready high; returns the captured response and latency.
    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                                 input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n;
        sel = s; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        d_ready = 1'b1;
        a_valid = 1'b1;
        n = 0;
        while (!o_a_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("a_ready before accept", 64'(o_a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
        r_lat = 1;
        while (!o_d_valid && r_lat < 50) begin
            tick();
            r_lat++;
        end
        r_op = o_d_opcode; r_den = o_d_denied; r_data = o_d_data;
        r_src = o_d_source; r_size = o_d_size;
        tick();
        checkOutput("a_ready after D handshake", 64'(o_a_ready), 64'd1);
    endtask

    initial begin
        sel = 1'b0; a_valid = 1'b1; a_opcode = A_GET; a_size = 2'd3; a_source = 4'd0;
        a_address = BASE; a_mask = 8'hFF; a_data = 64'd0; d_ready = 1'b1;

        addVec(0, A_PUT_FULL,    2'd3, 4'd1,  BASE + 64'd8,  8'hFF, 64'h1122_3344_5566_7788, D_ACCESS_ACK,      0, 64'd0, 1);
        addVec(0, A_GET,         2'd3, 4'd2,  BASE + 64'd8,  8'hFF, 64'd0,                   D_ACCESS_ACK_DATA, 0, 64'h1122_3344_5566_7788, 1);
        addVec(0, A_PUT_PARTIAL, 2'd3, 4'd3,  BASE + 64'd8,  8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, D_ACCESS_ACK,      0, 64'd0, 1);
        addVec(0, A_GET,         2'd3, 4'd4,  BASE + 64'd8,  8'hFF, 64'd0,                   D_ACCESS_ACK_DATA, 0, 64'h1122_3344_AAAA_BBBB, 1);
        addVec(0, A_PUT_FULL,    2'd3, 4'd6,  BASE,          8'hFF, 64'h0123_4567_89AB_CDEF, D_ACCESS_ACK,      0, 64'd0, 1);
        addVec(0, A_GET,         2'd3, 4'd7,  BASE + 64'(8 * DEPTH), 8'hFF, 64'd0,           D_ACCESS_ACK_DATA, 1, 64'd0, 1);
        addVec(0, A_PUT_FULL,    2'd2, 4'd8,  BASE + 64'd2,  8'h0F, 64'd0,                   D_ACCESS_ACK,      1, 64'd0, 1);
        addVec(0, A_PUT_FULL,    2'd2, 4'd9,  BASE + 64'd4,  8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, D_ACCESS_ACK,      1, 64'd0, 1);
        addVec(0, A_GET,         2'd3, 4'd10, BASE,          8'hFF, 64'd0,                   D_ACCESS_ACK_DATA, 0, 64'h0123_4567_89AB_CDEF, 1);
        addVec(0, A_PUT_FULL,    2'd2, 4'd11, BASE + 64'd4,  8'hF0, 64'hDEAD_BEEF_0000_0000, D_ACCESS_ACK,      0, 64'd0, 1);
        addVec(0, A_PUT_PARTIAL, 2'd3, 4'd12, BASE,          8'h00, 64'hFFFF_FFFF_FFFF_FFFF, D_ACCESS_ACK,      0, 64'd0, 1);
        addVec(0, A_GET,         2'd2, 4'd13, BASE + 64'd4,  8'hF0, 64'd0,                   D_ACCESS_ACK_DATA, 0, 64'hDEAD_BEEF_89AB_CDEF, 1);
        addVec(0, A_GET,         2'd3, 4'd14, BASE - 64'd8,  8'hFF, 64'd0,                   D_ACCESS_ACK_DATA, 1, 64'd0, 1);
        addVec(0, A_GET,         2'd1, 4'd15, BASE + 64'd1,  8'h06, 64'd0,                   D_ACCESS_ACK_DATA, 1, 64'd0, 1);
        addVec(0, 3'd2,          2'd3, 4'd0,  BASE + 64'd8,  8'hFF, 64'd0,                   D_ACCESS_ACK,      1, 64'd0, 1);
        addVec(0, A_PUT_PARTIAL, 2'd3, 4'd1,  BASE + 64'(8 * (DEPTH - 1)), 8'hFF, 64'h0A0B_0C0D_0E0F_1011, D_ACCESS_ACK, 0, 64'd0, 1);
        addVec(0, A_GET,         2'd0, 4'd2,  BASE + 64'(8 * (DEPTH - 1)) + 64'd3, 8'h08, 64'd0, D_ACCESS_ACK_DATA, 0, 64'h0A0B_0C0D_0E0F_1011, 1);
        addVec(0, A_GET,         2'd3, 4'd3,  BASE + 64'd8,  8'hFF, 64'd0,                   D_ACCESS_ACK_DATA, 0, 64'h1122_3344_AAAA_BBBB, 1);

        // Reset held with a request pending: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset a_ready dut0", 64'(bus0.a_ready), 64'd0);
            checkOutput("reset d_valid dut0", 64'(bus0.d_valid), 64'd0);
            checkOutput("reset a_ready dut3", 64'(bus3.a_ready), 64'd0);
            checkOutput("reset d_valid dut3", 64'(bus3.d_valid), 64'd0);
        end
        checkOutput("reset d_data", o_d_data, 64'd0);
        checkOutput("reset d_source", 64'(o_d_source), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("a_ready after release", 64'(o_a_ready), 64'd1);
        a_valid = 1'b0;
        tick();
        checkOutput("no accept during reset", 64'(o_d_valid), 64'd0);
        checkOutput("a_ready idle after reset", 64'(o_a_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].size, vecs[i].src,
                          vecs[i].addr, vecs[i].mask, vecs[i].data);
            checkOutput($sformatf("vec%0d d_opcode", i), 64'(r_op), 64'(vecs[i].exp_op));
            checkOutput($sformatf("vec%0d d_denied", i), 64'(r_den), 64'(vecs[i].exp_denied));
            checkOutput($sformatf("vec%0d d_data", i), r_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d d_source", i), 64'(r_src), 64'(vecs[i].src));
            checkOutput($sformatf("vec%0d d_size", i), 64'(r_size), 64'(vecs[i].size));
            checkOutput($sformatf("vec%0d latency", i), 64'(r_lat), 64'(vecs[i].exp_lat));
        end

        // Three wait states, then a response held under backpressure.
        applyStimulus(1, A_PUT_FULL, 2'd3, 4'd1, BASE + 64'd8, 8'hFF, 64'hCAFE_F00D_1234_5678);
        checkOutput("w3 put latency", 64'(r_lat), 64'd4);
        checkOutput("w3 put denied", 64'(r_den), 64'd0);

        sel = 1'b1; a_opcode = A_GET; a_size = 2'd3; a_source = 4'd5;
        a_address = BASE + 64'd8; a_mask = 8'hFF; a_data = 64'd0;
        d_ready = 1'b0;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checkOutput("a_ready during wait", 64'(o_a_ready), 64'd0);
        r_lat = 1;
        while (!o_d_valid && r_lat < 50) begin
            tick();
            r_lat++;
        end
        checkOutput("w3 get latency", 64'(r_lat), 64'd4);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("hold%0d d_valid", i), 64'(o_d_valid), 64'd1);
            checkOutput($sformatf("hold%0d d_source", i), 64'(o_d_source), 64'd5);
            checkOutput($sformatf("hold%0d d_data", i), o_d_data, 64'hCAFE_F00D_1234_5678);
            checkOutput($sformatf("hold%0d d_opcode", i), 64'(o_d_opcode), 64'(D_ACCESS_ACK_DATA));
            checkOutput($sformatf("hold%0d a_ready", i), 64'(o_a_ready), 64'd0);
            tick();
        end
        checkOutput("hold end d_valid", 64'(o_d_valid), 64'd1);
        d_ready = 1'b1;
        tick();
        checkOutput("release a_ready", 64'(o_a_ready), 64'd1);
        checkOutput("release d_valid", 64'(o_d_valid), 64'd0);

        // Reset in the second wait cycle of a Put drops it without touching RAM.
        a_opcode = A_PUT_FULL; a_size = 2'd3; a_source = 4'd6;
        a_address = BASE + 64'd8; a_mask = 8'hFF; a_data = 64'h5555_5555_5555_5555;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst d_valid", 64'(o_d_valid), 64'd0);
        checkOutput("midrst a_ready", 64'(o_a_ready), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("midrst quiet%0d d_valid", i), 64'(o_d_valid), 64'd0);
        end
        applyStimulus(1, A_GET, 2'd3, 4'd7, BASE + 64'd8, 8'hFF, 64'd0);
        checkOutput("midrst get d_data", r_data, 64'hCAFE_F00D_1234_5678);
        checkOutput("midrst get d_denied", 64'(r_den), 64'd0);
        checkOutput("midrst get d_source", 64'(r_src), 64'd7);
        checkOutput("midrst get latency", 64'(r_lat), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
